// File: rtl/pc_next_unit.sv
// Program-counter / next-PC stage of the single-cycle MIPS datapath.
// Owns the fetch PC and picks the next PC from jr, jump, conditional branch or
// sequential flow. Also keeps saturating retired-instruction and taken-branch
// counters for lab debug.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             branch_ne_i,
    input  logic             zero_i,
    input  logic             jump_i,
    input  logic             jr_i,
    input  logic [31:0]      imm_ext_i,
    input  logic [25:0]      jump_target_i,
    input  logic [31:0]      rs_data_i,
    input  logic             halt_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             valid_o,
    output logic             taken_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] branch_cnt_o
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               taken_q, taken_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;

    logic [31:0]        pc_plus4;
    logic [31:0]        imm_shifted;
    logic [31:0]        branch_target;
    logic [31:0]        jump_target;
    logic [31:0]        jr_target;
    logic               branch_taken;
    logic [CNT_W-1:0]   instr_cnt_inc;
    logic [CNT_W-1:0]   branch_cnt_inc;

    // Target computation; all adds wrap silently modulo 2^32.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        imm_shifted   = imm_ext_i << 2;
        branch_target = pc_plus4 + imm_shifted;
        jump_target   = {pc_plus4[31:28], jump_target_i, 2'b00};
        jr_target     = {rs_data_i[31:2], 2'b00};
        branch_taken  = branch_i && (branch_ne_i ? !zero_i : zero_i);
    end

    // Saturating increments: counters stick at all-ones instead of wrapping.
    always_comb begin
        instr_cnt_inc  = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);
        branch_cnt_inc = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + CNT_W'(1);
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        taken_d      = taken_q;
        misalign_d   = misalign_q;
        instr_cnt_d  = instr_cnt_q;
        branch_cnt_d = branch_cnt_q;

        unique case (state_q)
            StBoot: begin
                // Single dead cycle at RESET_PC; control inputs are ignored.
                state_d = StRun;
            end
            StRun: begin
                if (!stall_i) begin
                    instr_cnt_d = instr_cnt_inc;
                    taken_d     = 1'b0;
                    misalign_d  = 1'b0;
                    if (halt_i) begin
                        // Halt beats any redirect; the halt itself retires.
                        state_d = StHalt;
                    end else if (jr_i) begin
                        pc_d       = jr_target;
                        taken_d    = 1'b1;
                        misalign_d = |rs_data_i[1:0];
                    end else if (jump_i) begin
                        pc_d    = jump_target;
                        taken_d = 1'b1;
                    end else if (branch_taken) begin
                        pc_d         = branch_target;
                        taken_d      = 1'b1;
                        branch_cnt_d = branch_cnt_inc;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            StHalt: begin
                // Frozen until reset.
                taken_d = 1'b0;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            taken_q      <= 1'b0;
            misalign_q   <= 1'b0;
            instr_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            taken_q      <= taken_d;
            misalign_q   <= misalign_d;
            instr_cnt_q  <= instr_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        pc_o         = pc_q;
        pc_plus4_o   = pc_plus4;
        valid_o      = (state_q == StRun);
        taken_o      = taken_q;
        misalign_o   = misalign_q;
        instr_cnt_o  = instr_cnt_q;
        branch_cnt_o = branch_cnt_q;
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, the latter used to observe counter saturation.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst, stall, branch, branch_ne, zero, jump, jr, halt;
    logic [31:0] imm_ext, rs_data;
    logic [25:0] jump_target;

    logic [31:0] pc, pc_plus4;
    logic        valid, taken, misalign;
    logic [15:0] instr_cnt, branch_cnt;

    logic [31:0] s_pc, s_pc_plus4;
    logic        s_valid, s_taken, s_misalign;
    logic [3:0]  s_instr_cnt, s_branch_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_i = 0;
    int exp_b = 0;

    always #5 clk = ~clk;

    pc_next_unit u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .branch_i      (branch),
        .branch_ne_i   (branch_ne),
        .zero_i        (zero),
        .jump_i        (jump),
        .jr_i          (jr),
        .imm_ext_i     (imm_ext),
        .jump_target_i (jump_target),
        .rs_data_i     (rs_data),
        .halt_i        (halt),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .valid_o       (valid),
        .taken_o       (taken),
        .misalign_o    (misalign),
        .instr_cnt_o   (instr_cnt),
        .branch_cnt_o  (branch_cnt)
    );

    pc_next_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (4)
    ) u_sat (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .branch_i      (branch),
        .branch_ne_i   (branch_ne),
        .zero_i        (zero),
        .jump_i        (jump),
        .jr_i          (jr),
        .imm_ext_i     (imm_ext),
        .jump_target_i (jump_target),
        .rs_data_i     (rs_data),
        .halt_i        (halt),
        .pc_o          (s_pc),
        .pc_plus4_o    (s_pc_plus4),
        .valid_o       (s_valid),
        .taken_o       (s_taken),
        .misalign_o    (s_misalign),
        .instr_cnt_o   (s_instr_cnt),
        .branch_cnt_o  (s_branch_cnt)
    );

    // One clock edge; outputs are settled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge in RUN that retires di instructions and db taken branches.
    task automatic adv(input int di, input int db);
        tick();
        exp_i += di;
        exp_b += db;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_instr"}, 32'(instr_cnt), 32'(exp_i));
        chk({tag, "_brcnt"}, 32'(branch_cnt), 32'(exp_b));
    endtask

    task automatic clr_ctl();
        stall = 0; branch = 0; branch_ne = 0; zero = 0; jump = 0; jr = 0; halt = 0;
        imm_ext = 32'h0; rs_data = 32'h0; jump_target = 26'h0;
    endtask

    initial begin
        clr_ctl();
        rst = 1;

        // Reset held two cycles: BOOT state at RESET_PC.
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_taken", 32'(taken), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk_cnt("rst");

        rst = 0;
        tick();
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", 32'(valid), 32'h1);
        chk_cnt("boot");
        adv(1, 0); adv(1, 0); adv(1, 0);
        chk("seq_pc", pc, 32'h0000_000C);
        chk_cnt("seq");
        adv(1, 0);
        chk("seq_pc10", pc, 32'h0000_0010);

        // Branches.
        branch = 1; zero = 1; imm_ext = 32'hFFFF_FFFC;
        adv(1, 1);
        chk("beq_t_pc", pc, 32'h0000_0004);
        chk("beq_t_taken", 32'(taken), 32'h1);
        chk("beq_t_p4", pc_plus4, 32'h0000_0008);
        chk_cnt("beq_t");

        clr_ctl(); jr = 1; rs_data = 32'h10;
        adv(1, 0);
        chk("jr10_pc", pc, 32'h0000_0010);
        clr_ctl(); branch = 1; zero = 0; imm_ext = 32'hFFFF_FFFC;
        adv(1, 0);
        chk("beq_nt_pc", pc, 32'h0000_0014);
        chk("beq_nt_taken", 32'(taken), 32'h0);
        chk_cnt("beq_nt");

        clr_ctl(); jr = 1; rs_data = 32'h10;
        adv(1, 0);
        clr_ctl(); branch = 1; branch_ne = 1; zero = 0; imm_ext = 32'h3;
        adv(1, 1);
        chk("bne_t_pc", pc, 32'h0000_0020);
        chk("bne_t_taken", 32'(taken), 32'h1);
        chk_cnt("bne_t");

        // imm = -1 branches to itself.
        clr_ctl(); branch = 1; zero = 1; imm_ext = 32'hFFFF_FFFF;
        adv(1, 1);
        chk("beq_self_pc", pc, 32'h0000_0020);
        chk_cnt("beq_self");

        // Jumps.
        clr_ctl(); jr = 1; rs_data = 32'h3000_0010;
        adv(1, 0);
        chk("jr_hi_pc", pc, 32'h3000_0010);
        clr_ctl(); jump = 1; jump_target = 26'h000_0040;
        adv(1, 0);
        chk("j_pc", pc, 32'h3000_0100);
        chk("j_taken", 32'(taken), 32'h1);
        clr_ctl(); jr = 1; rs_data = 32'h0000_0206;
        adv(1, 0);
        chk("jr_mis_pc", pc, 32'h0000_0204);
        chk("jr_mis_flag", 32'(misalign), 32'h1);
        clr_ctl();
        adv(1, 0);
        chk("post_mis_pc", pc, 32'h0000_0208);
        chk("post_mis_flag", 32'(misalign), 32'h0);
        chk("post_mis_taken", 32'(taken), 32'h0);

        // Stall with a taken branch pending.
        clr_ctl(); jr = 1; rs_data = 32'h40;
        adv(1, 0);
        clr_ctl(); branch = 1; zero = 1; imm_ext = 32'h4; stall = 1;
        for (int k = 0; k < 3; k++) begin
            adv(0, 0);
            chk("stall_pc", pc, 32'h0000_0040);
            chk("stall_taken", 32'(taken), 32'h1);
            chk_cnt("stall");
        end
        stall = 0;
        adv(1, 1);
        chk("unstall_pc", pc, 32'h0000_0054);
        chk_cnt("unstall");

        // Priority: jr over jump over branch.
        jr = 1; rs_data = 32'h100; jump = 1; jump_target = 26'h3FF_FFFF;
        adv(1, 0);
        chk("prio_jr_pc", pc, 32'h0000_0100);
        chk_cnt("prio_jr");
        jr = 0;
        adv(1, 0);
        chk("prio_j_pc", pc, 32'h0FFF_FFFC);
        chk_cnt("prio_j");

        // Halt with a simultaneous redirect: halt wins, then frozen.
        clr_ctl(); jr = 1; rs_data = 32'h50;
        adv(1, 0);
        clr_ctl(); halt = 1; jump = 1; jump_target = 26'h123;
        adv(1, 0);
        chk("halt_pc", pc, 32'h0000_0050);
        chk("halt_valid", 32'(valid), 32'h0);
        chk("halt_taken", 32'(taken), 32'h0);
        chk_cnt("halt");
        halt = 0;
        for (int k = 0; k < 10; k++) begin
            jump = ~jump; branch = 1; zero = 1;
            adv(0, 0);
            chk("halted_pc", pc, 32'h0000_0050);
            chk("halted_valid", 32'(valid), 32'h0);
            chk_cnt("halted");
        end
        clr_ctl(); rst = 1;
        tick();
        exp_i = 0; exp_b = 0;
        chk("hrst_pc", pc, 32'h0);
        chk("hrst_valid", 32'(valid), 32'h0);
        chk_cnt("hrst");
        rst = 0;
        tick();
        chk("hrst_run_valid", 32'(valid), 32'h1);
        chk("hrst_run_pc", pc, 32'h0);

        // Reset asserted during a stall.
        adv(1, 0); adv(1, 0);
        chk("pre_srst_pc", pc, 32'h0000_0008);
        branch = 1; zero = 1; imm_ext = 32'h4; stall = 1;
        adv(0, 0);
        rst = 1;
        tick();
        exp_i = 0; exp_b = 0;
        chk("srst_pc", pc, 32'h0);
        chk("srst_valid", 32'(valid), 32'h0);
        chk_cnt("srst");
        clr_ctl(); rst = 0;
        tick();
        chk("srst_run_valid", 32'(valid), 32'h1);
        chk("srst_run_pc", pc, 32'h0);

        // PC wrap-around.
        jr = 1; rs_data = 32'hFFFF_FFFC;
        adv(1, 0);
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        clr_ctl();
        adv(1, 0);
        chk("wrap_pc", pc, 32'h0);

        // Counter saturation on the 4-bit instance.
        rst = 1;
        tick();
        rst = 0;
        tick();
        exp_i = 0; exp_b = 0;
        branch = 1; zero = 1; imm_ext = 32'h0;
        for (int k = 0; k < 20; k++) adv(1, 1);
        chk("sat_brcnt", 32'(s_branch_cnt), 32'd15);
        chk("sat_instr", 32'(s_instr_cnt), 32'd15);
        chk_cnt("wide_cnt");
        chk("sat_pc", s_pc, 32'h0000_0050);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter and next-PC stage of the single-cycle MIPS datapath.
- Consumes the 32-bit sign-extended immediate from the sign-extension stage, shifts it left by 2 and adds it to PC+4 to form branch targets.
- Also resolves jump and jr, holds the PC on stall, and keeps taken-branch and instruction counters for lab debug.
- Output pc_o drives the instruction memory address; pc_plus4_o feeds the branch adder and the jal/link write-back mux.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the instruction and branch counters

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
stall_i  input  1  hold PC and counters this cycle
branch_i  input  1  current instruction is a conditional branch
branch_ne_i  input  1  1 = bne, 0 = beq (valid only with branch_i)
zero_i  input  1  ALU zero flag for the current instruction
jump_i  input  1  j/jal
jr_i  input  1  jr
imm_ext_i  input  32  sign-extended immediate
jump_target_i  input  26  instr[25:0]
rs_data_i  input  32  register rs value for jr
halt_i  input  1  halt request
pc_o  output  32  current PC
pc_plus4_o  output  32  pc_o + 4, combinational
valid_o  output  1  pc_o is a live fetch address
taken_o  output  1  registered: previous update redirected the PC
misalign_o  output  1  registered: previous jr target had rs_data_i[1:0] != 0
instr_cnt_o  output  CNT_W  retired-instruction count
branch_cnt_o  output  CNT_W  taken conditional-branch count

Behaviour:
- FSM states are BOOT, RUN and HALT.
- Reset (rst_i=1 at a clock edge, from any state, including mid-stall or HALT):
  - state=BOOT, pc_o=RESET_PC.
  - valid_o=0, taken_o=0, misalign_o=0.
  - Both counters = 0.
  - Reset has priority over every other input.
- BOOT: lasts exactly one cycle. pc_o holds RESET_PC, valid_o=0, all control inputs ignored, then state goes to RUN.
- RUN: valid_o=1. Next-PC priority per edge:
  - If stall_i: PC, counters, taken_o and misalign_o hold their values.
  - Else if halt_i: state goes to HALT and PC holds. instr_cnt_o increments, because the halt instruction retires.
  - Else if jr_i: PC = {rs_data_i[31:2], 2'b00}. misalign_o = |rs_data_i[1:0]. taken_o=1.
  - Else if jump_i: PC = {pc_plus4_o[31:28], jump_target_i, 2'b00}. taken_o=1.
  - Else if branch_i and (branch_ne_i ? ~zero_i : zero_i): PC = pc_plus4_o + (imm_ext_i << 2). taken_o=1. branch_cnt_o increments.
  - Else: PC = pc_plus4_o. taken_o=0.
  - misalign_o=0 on every non-stalled RUN update except a jr.
  - instr_cnt_o increments on every non-stalled RUN update.
- HALT: pc_o frozen, valid_o=0, taken_o=0, counters frozen, all inputs except rst_i ignored. Exit is by reset only.
- Arithmetic:
  - All adds are 32-bit modulo 2^32; wrap-around is silent.
  - Negative immediates give backward branches, e.g. imm=-1 gives target = PC.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
- Simultaneous inputs:
  - jr_i, jump_i and branch_i together: priority above applies.
  - halt_i together with any redirect: halt wins and PC holds.
- Latency: control inputs act at the next edge; pc_o is registered; pc_plus4_o is combinational from pc_o.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then release with RESET_PC=0 -> pc_o=0 with valid_o=0 for one cycle, then pc_o=0 valid; after 3 free-running cycles pc_o=0x0C and instr_cnt_o=3.
- Branches: at pc_o=0x10, branch_i=1, branch_ne_i=0, zero_i=1, imm_ext_i=0xFFFFFFFC -> pc_o=0x04, taken_o=1, branch_cnt_o+1. Same with zero_i=0 -> pc_o=0x14, taken_o=0. bne with zero_i=0 and imm=3 -> pc_o=0x20.
- Jumps: at pc_o=0x30000010, jump_i=1, jump_target_i=0x0000040 -> pc_o=0x30000100. jr_i with rs_data_i=0x00000206 -> pc_o=0x204, misalign_o=1 next cycle, then 0 after the following sequential update.
- Stall and priority: stall_i=1 for 3 cycles at pc_o=0x40 with branch_i taken -> pc_o, counters and taken_o unchanged; releasing the stall takes the branch. jr_i, jump_i and a taken branch together -> jr target chosen.
- Halt and reset mid-operation: halt_i at pc_o=0x50 -> pc_o stays 0x50, valid_o=0, counters frozen for 10 cycles despite jump_i toggling; rst_i -> BOOT then RUN from RESET_PC. Reset asserted during a stall -> same result.
- Wrap and saturation: pc_o=0xFFFFFFFC sequential -> pc_o=0x00000000. With CNT_W=4, 20 taken branches -> branch_cnt_o=15, and instr_cnt_o=15 once 15 or more instructions have retired.
